// File: rtl/jtag_host_pkg.sv
// Shared types and constants for the JTAG host master.
package jtag_host_pkg;

    typedef enum logic [1:0] {
        OP_TAP_RESET = 2'd0,
        OP_IR_SCAN   = 2'd1,
        OP_DR_SCAN   = 2'd2,
        OP_RSVD      = 2'd3
    } jtag_op_e;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RST_WALK,
        HEAD,
        SHIFT,
        TAIL,
        RESP
    } jtag_state_e;

    localparam int unsigned RST_WALK_LEN = 5;
    localparam int unsigned IR_HEAD_LEN  = 4;
    localparam int unsigned DR_HEAD_LEN  = 3;
    localparam int unsigned TAIL_LEN     = 2;

    // TMS for head period idx: IR walks 1,1,0,0 and DR walks 1,0,0 into Shift.
    function automatic logic head_tms(input jtag_op_e op, input logic [5:0] idx);
        return (idx == 6'd0) || ((op == OP_IR_SCAN) && (idx == 6'd1));
    endfunction

    function automatic logic [5:0] head_len(input jtag_op_e op);
        return (op == OP_IR_SCAN) ? 6'(IR_HEAD_LEN) : 6'(DR_HEAD_LEN);
    endfunction

endpackage

// File: rtl/jtag_host_tck_gen.sv
// TCK divider: CLK_DIV cycles low then CLK_DIV cycles high per period while run is set.
// fall_strobe marks the CLK edge that starts a low half, rise_strobe the edge that starts a high half.
module jtag_host_tck_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tck,
    output logic fall_strobe,
    output logic rise_strobe
);

    localparam logic [8:0] HALF    = 9'(CLK_DIV);
    localparam logic [8:0] FULL_M1 = 9'(2 * CLK_DIV - 1);

    logic [8:0] cnt;

    // Strobes are decoded from the phase counter so they coincide with the TCK toggle edge.
    always_comb begin
        fall_strobe = run && (cnt == '0);
        rise_strobe = run && (cnt == HALF);
    end

    // Phase counter and registered TCK; both park at zero/low when not running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (!run) begin
            cnt <= '0;
            tck <= 1'b0;
        end else begin
            cnt <= (cnt == FULL_M1) ? '0 : cnt + 9'd1;
            if (rise_strobe)
                tck <= 1'b1;
            else if (fall_strobe)
                tck <= 1'b0;
        end
    end

endmodule

// File: rtl/jtag_host_master.sv
// JTAG host master: command/response front end driving a target TAP.
// Optional macro JTAG_HOST_MASTER_TRST_EN adds the TGT_TRSTB output.
module jtag_host_master
    import jtag_host_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned MAX_LEN = 32
) (
    input  logic               CLK,
    input  logic               RESETN,
    input  logic               CMD_VALID,
    output logic               CMD_READY,
    input  logic [1:0]         CMD_OP,
    input  logic [5:0]         CMD_LEN,
    input  logic [MAX_LEN-1:0] CMD_DATA,
    output logic               RSP_VALID,
    input  logic               RSP_READY,
    output logic [MAX_LEN-1:0] RSP_DATA,
    output logic               RSP_ERR,
    output logic               TGT_TCK,
    output logic               TGT_TMS,
    output logic               TGT_TDI,
`ifdef JTAG_HOST_MASTER_TRST_EN
    output logic               TGT_TRSTB,
`endif
    input  logic               TGT_TDO
);

    localparam logic [5:0] WALK_LEN6 = 6'(RST_WALK_LEN);
    localparam logic [5:0] TAIL_LEN6 = 6'(TAIL_LEN);

    jtag_state_e        state;
    jtag_op_e           op_q;
    logic [5:0]         len_q;
    logic [MAX_LEN-1:0] data_q;
    logic [5:0]         idx;
    logic [5:0]         shift_pos;
    logic               shifting;
    logic               run;
    logic               fall_strobe;
    logic               rise_strobe;
    logic               cmd_bad;
    logic               tdi_bit;

    jtag_host_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .clk         (CLK),
        .rst_n       (RESETN),
        .run         (run),
        .tck         (TGT_TCK),
        .fall_strobe (fall_strobe),
        .rise_strobe (rise_strobe)
    );

    // Command legality and the TDI bit for the shift period about to start.
    always_comb begin
        cmd_bad = (CMD_LEN == 6'd0) || ({26'd0, CMD_LEN} > 32'(MAX_LEN)) || (CMD_OP == OP_RSVD);
        tdi_bit = |(data_q & (MAX_LEN'(1) << idx));
    end

    // Control FSM: on each fall strobe it drives the period that is starting and advances idx;
    // a fall strobe with no period left marks the end of the last high half.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state     <= INIT;
            op_q      <= OP_TAP_RESET;
            len_q     <= '0;
            data_q    <= '0;
            idx       <= '0;
            shift_pos <= '0;
            shifting  <= 1'b0;
            run       <= 1'b1;
            TGT_TMS   <= 1'b1;
            TGT_TDI   <= 1'b0;
            CMD_READY <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_DATA  <= '0;
            RSP_ERR   <= 1'b0;
`ifdef JTAG_HOST_MASTER_TRST_EN
            TGT_TRSTB <= 1'b0;
`endif
        end else begin
            // The last shift bit is sampled after the FSM has already moved to TAIL.
            if (rise_strobe && shifting)
                RSP_DATA <= RSP_DATA | (MAX_LEN'(TGT_TDO) << shift_pos);

            case (state)
                IDLE: begin
                    if (CMD_VALID && CMD_READY) begin
                        CMD_READY <= 1'b0;
                        op_q      <= jtag_op_e'(CMD_OP);
                        len_q     <= CMD_LEN;
                        data_q    <= CMD_DATA;
                        idx       <= '0;
                        RSP_DATA  <= '0;
                        RSP_ERR   <= 1'b0;
                        if (cmd_bad) begin
                            state     <= RESP;
                            RSP_VALID <= 1'b1;
                            RSP_ERR   <= 1'b1;
                        end else begin
                            run   <= 1'b1;
                            state <= (jtag_op_e'(CMD_OP) == OP_TAP_RESET) ? RST_WALK : HEAD;
                        end
                    end
                end
                INIT, RST_WALK: begin
                    if (fall_strobe) begin
                        if (idx == WALK_LEN6 + 6'd1) begin
                            run <= 1'b0;
                            if (state == INIT) begin
                                state     <= IDLE;
                                CMD_READY <= 1'b1;
                            end else begin
                                state     <= RESP;
                                RSP_VALID <= 1'b1;
                            end
                        end else begin
                            TGT_TMS <= (idx < WALK_LEN6);
`ifdef JTAG_HOST_MASTER_TRST_EN
                            TGT_TRSTB <= (idx >= WALK_LEN6);
`endif
                            idx <= idx + 6'd1;
                        end
                    end
                end
                HEAD: begin
                    if (fall_strobe) begin
                        TGT_TMS <= head_tms(op_q, idx);
                        if (idx == head_len(op_q) - 6'd1) begin
                            state <= SHIFT;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 6'd1;
                        end
                    end
                end
                SHIFT: begin
                    if (fall_strobe) begin
                        TGT_TMS   <= (idx == len_q - 6'd1);
                        TGT_TDI   <= tdi_bit;
                        shifting  <= 1'b1;
                        shift_pos <= idx;
                        if (idx == len_q - 6'd1) begin
                            state <= TAIL;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 6'd1;
                        end
                    end
                end
                TAIL: begin
                    if (fall_strobe) begin
                        shifting <= 1'b0;
                        TGT_TDI  <= 1'b0;
                        if (idx == TAIL_LEN6) begin
                            run       <= 1'b0;
                            state     <= RESP;
                            RSP_VALID <= 1'b1;
                        end else begin
                            TGT_TMS <= (idx == 6'd0);
                            idx     <= idx + 6'd1;
                        end
                    end
                end
                RESP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        state     <= IDLE;
                        CMD_READY <= 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_host_master.sv
// Directed bench for jtag_host_master (CLK_DIV=2, MAX_LEN=32), with an optional
// TGT_TRSTB check when JTAG_HOST_MASTER_TRST_EN is defined.
module tb_jtag_host_master;

    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned MAX_LEN = 32;

    logic               CLK = 1'b0;
    logic               RESETN = 1'b0;
    logic               CMD_VALID = 1'b0;
    logic               CMD_READY;
    logic [1:0]         CMD_OP = 2'd0;
    logic [5:0]         CMD_LEN = 6'd0;
    logic [MAX_LEN-1:0] CMD_DATA = '0;
    logic               RSP_VALID;
    logic               RSP_READY = 1'b0;
    logic [MAX_LEN-1:0] RSP_DATA;
    logic               RSP_ERR;
    logic               TGT_TCK;
    logic               TGT_TMS;
    logic               TGT_TDI;
    logic               TGT_TDO;
`ifdef JTAG_HOST_MASTER_TRST_EN
    logic               TGT_TRSTB;
    logic               trst_log [256];
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Target model: 0 = TDI looped back with one TCK delay, 1 = tied high, 2 = tied low.
    int          tdo_mode = 0;
    logic        lb = 1'b0;
    int unsigned tck_count = 0;
    logic        tms_log [256];
    logic        tdi_log [256];

    jtag_host_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_OP    (CMD_OP),
        .CMD_LEN   (CMD_LEN),
        .CMD_DATA  (CMD_DATA),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .RSP_DATA  (RSP_DATA),
        .RSP_ERR   (RSP_ERR),
        .TGT_TCK   (TGT_TCK),
        .TGT_TMS   (TGT_TMS),
        .TGT_TDI   (TGT_TDI),
`ifdef JTAG_HOST_MASTER_TRST_EN
        .TGT_TRSTB (TGT_TRSTB),
`endif
        .TGT_TDO   (TGT_TDO)
    );

    always #5 CLK = ~CLK;

    assign TGT_TDO = (tdo_mode == 1) ? 1'b1 : ((tdo_mode == 0) ? lb : 1'b0);

    // Log TMS/TDI (and TRSTB) at every rising TCK and model the looped-back target register.
    always @(posedge TGT_TCK) begin
        if (tck_count < 256) begin
            tms_log[tck_count[7:0]] <= TGT_TMS;
            tdi_log[tck_count[7:0]] <= TGT_TDI;
`ifdef JTAG_HOST_MASTER_TRST_EN
            trst_log[tck_count[7:0]] <= TGT_TRSTB;
`endif
        end
        tck_count <= tck_count + 1;
        lb        <= TGT_TDI;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pack n logged bits starting at period base, first period in bit 0 (sel 0=TMS, 1=TDI, 2=TRSTB).
    function automatic logic [63:0] log_bits(input int sel, input int unsigned base, input int unsigned n);
        logic [63:0] r;
        r = '0;
        for (int unsigned k = 0; k < n; k++) begin
            if (base + k < 256) begin
                if (sel == 0)
                    r[k] = tms_log[base + k];
                else if (sel == 1)
                    r[k] = tdi_log[base + k];
`ifdef JTAG_HOST_MASTER_TRST_EN
                else
                    r[k] = trst_log[base + k];
`endif
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Release reset at a falling edge and check the INIT walk plus CMD_READY timing.
    task automatic init_walk(input string tag);
        int unsigned base;
        bit          early;
        @(negedge CLK);
        RESETN = 1'b1;
        base   = tck_count;
        early  = 1'b0;
        repeat (24) begin
            tick();
            if (CMD_READY) early = 1'b1;
        end
        check_eq({tag, "_ready_early"}, 64'(early), 64'd0);
        tick();
        check_eq({tag, "_ready"}, 64'(CMD_READY), 64'd1);
        check_eq({tag, "_periods"}, 64'(tck_count - base), 64'd6);
        check_eq({tag, "_tms"}, log_bits(0, base, 6), 64'h1F);
        check_eq({tag, "_no_rsp"}, 64'(RSP_VALID), 64'd0);
`ifdef JTAG_HOST_MASTER_TRST_EN
        check_eq({tag, "_trstb_seq"}, log_bits(2, base, 6), 64'h20);
        check_eq({tag, "_trstb_after"}, 64'(TGT_TRSTB), 64'd1);
`endif
    endtask

    task automatic send(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                        output int unsigned base);
        int w;
        w = 0;
        while (!CMD_READY && w < 200) begin
            tick();
            w++;
        end
        check_eq("cmd_ready_wait", 64'(CMD_READY), 64'd1);
        @(negedge CLK);
        CMD_OP    = op;
        CMD_LEN   = len;
        CMD_DATA  = data;
        CMD_VALID = 1'b1;
        base      = tck_count;
        tick();
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int w;
        w = 0;
        while (!RSP_VALID && w < 1000) begin
            tick();
            w++;
        end
        check_eq({tag, "_rsp_valid"}, 64'(RSP_VALID), 64'd1);
    endtask

    task automatic ack(input string tag);
        @(negedge CLK);
        RSP_READY = 1'b1;
        tick();
        RSP_READY = 1'b0;
        check_eq({tag, "_ack"}, 64'(RSP_VALID), 64'd0);
    endtask

    logic [1:0]  rej_op  [3] = '{2'd2, 2'd2, 2'd3};
    logic [5:0]  rej_len [3] = '{6'd0, 6'd33, 6'd8};

    initial begin
        int unsigned base;
        int unsigned t0;
        int          bad;
        int          w;
        logic [31:0] snap;

        // Reset values.
        repeat (3) tick();
        check_eq("rst_ctl", {58'd0, TGT_TCK, TGT_TMS, TGT_TDI, CMD_READY, RSP_VALID, RSP_ERR}, 64'b010000);
        check_eq("rst_data", 64'(RSP_DATA), 64'd0);
`ifdef JTAG_HOST_MASTER_TRST_EN
        check_eq("rst_trstb", 64'(TGT_TRSTB), 64'd0);
`endif
        init_walk("init");

        // TAP reset command: 6 periods, TMS 1,1,1,1,1,0.
        send(2'd0, 6'd8, 32'hFFFF_FFFF, base);
        wait_rsp("tap");
        check_eq("tap_err", 64'(RSP_ERR), 64'd0);
        check_eq("tap_data", 64'(RSP_DATA), 64'd0);
        check_eq("tap_periods", 64'(tck_count - base), 64'd6);
        check_eq("tap_tms", log_bits(0, base, 6), 64'h1F);
        ack("tap");

        // DR scan, LEN=8, 0xA5, loopback target: response is data shifted up one bit.
        tdo_mode = 0;
        send(2'd2, 6'd8, 32'h0000_00A5, base);
        wait_rsp("dr8");
        check_eq("dr8_data", 64'(RSP_DATA), 64'h4A);
        check_eq("dr8_err", 64'(RSP_ERR), 64'd0);
        check_eq("dr8_periods", 64'(tck_count - base), 64'd13);
        check_eq("dr8_tdi", log_bits(1, base + 3, 8), 64'hA5);
        check_eq("dr8_tms", log_bits(0, base, 13), 64'h0C01);

        // Response held off for 10 cycles.
        snap = RSP_DATA;
        t0   = tck_count;
        bad  = 0;
        repeat (10) begin
            tick();
            if (!RSP_VALID || RSP_DATA !== snap || CMD_READY) bad++;
        end
        check_eq("hold_stable", 64'(bad), 64'd0);
        check_eq("hold_no_tck", 64'(tck_count - t0), 64'd0);
        ack("dr8");

        // Rejected commands: LEN=0, LEN=33, opcode 3.
        for (int i = 0; i < 3; i++) begin
            send(rej_op[i], rej_len[i], 32'hFFFF_FFFF, base);
            check_eq("rej_valid", 64'(RSP_VALID), 64'd1);
            check_eq("rej_err", 64'(RSP_ERR), 64'd1);
            check_eq("rej_data", 64'(RSP_DATA), 64'd0);
            ack("rej");
            check_eq("rej_no_tck", 64'(tck_count - base), 64'd0);
        end

        // IR scan, LEN=5, 0x11, TDO tied high.
        tdo_mode = 1;
        send(2'd1, 6'd5, 32'h0000_0011, base);
        wait_rsp("ir5");
        check_eq("ir5_data", 64'(RSP_DATA), 64'h1F);
        check_eq("ir5_err", 64'(RSP_ERR), 64'd0);
        check_eq("ir5_periods", 64'(tck_count - base), 64'd11);
        check_eq("ir5_head", log_bits(0, base, 4), 64'h3);
        check_eq("ir5_tdi", log_bits(1, base + 4, 5), 64'h11);
        ack("ir5");

        // Single-bit DR scan: the only shift period is also the Exit1 period.
        send(2'd2, 6'd1, 32'h0000_0001, base);
        wait_rsp("dr1");
        check_eq("dr1_data", 64'(RSP_DATA), 64'h1);
        check_eq("dr1_periods", 64'(tck_count - base), 64'd6);
        check_eq("dr1_tms", log_bits(0, base, 6), 64'h19);
        ack("dr1");

        // Full-width DR scan with loopback.
        tdo_mode = 0;
        send(2'd2, 6'd32, 32'hDEAD_BEEF, base);
        wait_rsp("dr32");
        check_eq("dr32_data", 64'(RSP_DATA), 64'hBD5B_7DDE);
        check_eq("dr32_periods", 64'(tck_count - base), 64'd37);
        ack("dr32");

        // Reset during shift bit 3 of a 16-bit DR scan.
        send(2'd2, 6'd16, 32'h0000_1234, base);
        w = 0;
        while (tck_count < base + 7 && w < 500) begin
            tick();
            w++;
        end
        check_eq("mid_reach", 64'(tck_count >= base + 7), 64'd1);
        RESETN = 1'b0;
        #1;
        check_eq("mid_rst_ctl", {58'd0, TGT_TCK, TGT_TMS, TGT_TDI, CMD_READY, RSP_VALID, RSP_ERR}, 64'b010000);
        check_eq("mid_rst_data", 64'(RSP_DATA), 64'd0);
`ifdef JTAG_HOST_MASTER_TRST_EN
        check_eq("mid_rst_trstb", 64'(TGT_TRSTB), 64'd0);
`endif
        repeat (3) tick();
        check_eq("mid_no_rsp", 64'(RSP_VALID), 64'd0);
        init_walk("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
